test_port_writer: RTL and testbench

- Transmit end of the simulation test-port protocol.
- Sits on the processor-side data write bus.
- Buffers result words from the datapath, then emits BEGIN_SYMBOL, each buffered word, and END_SYMBOL as single-word writes to TEST_PORT.
- Honours the D-cache stall, and drops wen between writes so the checking monitor counts exactly one write per word.

---
 rtl/test_port_pkg.sv | 26 ++
 rtl/test_port_writer_if.sv | 13 +
 rtl/test_port_writer_fifo.sv | 66 ++++++
 rtl/test_port_writer.sv | 127 ++++++++++++
 tb/tb_test_port_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/test_port_pkg.sv
// Shared constants, state encoding and FIFO entry type for the test-port writer.
package test_port_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] TEST_PORT    = 30'h3FF;
    localparam logic [DATA_W-1:0] BEGIN_SYMBOL = 32'h0000_0168;
    localparam logic [DATA_W-1:0] END_SYMBOL   = 32'h0000_0D5D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEGIN,
        ST_GAP,
        ST_WAIT,
        ST_WORD,
        ST_END,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/test_port_writer_if.sv
// Processor-side data write bus as seen by the test-port writer.
interface test_port_writer_if;
    import test_port_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              stall;

    modport master (output addr, output data, output wen, input stall);
    modport slave  (input addr, input data, input wen, output stall);

endinterface

// File: rtl/test_port_writer_fifo.sv
// Synchronous result FIFO of {last, data} entries with a sticky overflow flag.
module result_fifo
    import test_port_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty,
    output logic   overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push while full is still taken.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/test_port_writer.sv
// Emits BEGIN_SYMBOL, the buffered result words and END_SYMBOL as single writes to TEST_PORT.
module test_port_writer
    import test_port_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               push,
    input  logic [DATA_W-1:0]  push_data,
    input  logic               push_last,
    output logic               full,
    output logic               overflow,
    test_port_writer_if.master bus,
    output logic               busy,
    output logic               done
);

    state_t state;
    entry_t head;
    logic   empty;
    logic   accept;
    logic   pop;
    logic   end_sent;
    logic   last_popped;

    assign accept = bus.wen && !bus.stall;
    assign pop    = (state == ST_WORD) && accept;

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{last: push_last, data: push_data}),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    // Report sequencer; every accepted write drops wen for exactly one GAP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bus.addr    <= '0;
            bus.data    <= '0;
            bus.wen     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            end_sent    <= 1'b0;
            last_popped <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_BEGIN;
                        bus.wen     <= 1'b1;
                        bus.addr    <= TEST_PORT;
                        bus.data    <= BEGIN_SYMBOL;
                        busy        <= 1'b1;
                        end_sent    <= 1'b0;
                        last_popped <= 1'b0;
                    end
                end
                ST_BEGIN: begin
                    if (accept) begin
                        bus.wen <= 1'b0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (end_sent) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (last_popped) begin
                        state    <= ST_END;
                        bus.wen  <= 1'b1;
                        bus.addr <= TEST_PORT;
                        bus.data <= END_SYMBOL;
                    end else if (!empty) begin
                        state    <= ST_WORD;
                        bus.wen  <= 1'b1;
                        bus.addr <= TEST_PORT;
                        bus.data <= head.data;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!empty) begin
                        state    <= ST_WORD;
                        bus.wen  <= 1'b1;
                        bus.addr <= TEST_PORT;
                        bus.data <= head.data;
                    end
                end
                ST_WORD: begin
                    // Head is stable here: only this state pops.
                    if (accept) begin
                        bus.wen     <= 1'b0;
                        last_popped <= head.last;
                        state       <= ST_GAP;
                    end
                end
                ST_END: begin
                    if (accept) begin
                        bus.wen  <= 1'b0;
                        end_sent <= 1'b1;
                        state    <= ST_GAP;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state   <= ST_IDLE;
                    bus.wen <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test_port_writer.sv
// Scoreboard bench for test_port_writer: expected writes are queued from stimulus and matched at the bus.
module tb_test_port_writer;

    localparam int unsigned DEPTH = 8;
    localparam logic [29:0] PORT  = 30'h3FF;
    localparam logic [31:0] BSYM  = 32'h0000_0168;
    localparam logic [31:0] ESYM  = 32'h0000_0D5D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_last = 1'b0;
    logic        full;
    logic        overflow;
    logic        busy;
    logic        done;

    test_port_writer_if bus();

    test_port_writer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .push      (push),
        .push_data (push_data),
        .push_last (push_last),
        .full      (full),
        .overflow  (overflow),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: {is_word, data} expected writes, plus entries buffered before start.
    logic [32:0] exp_q[$];
    logic [32:0] pre_q[$];
    int          acc_cyc[$];
    int          model_cnt = 0;
    bit          model_ovf = 0;
    bit          model_idle = 1;
    bit          collecting = 0;
    int          n_writes = 0;
    int          n_word_writes = 0;
    bit          prev_acc = 0;
    bit          prev_stall = 0;
    logic [29:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    task automatic model_reset();
        exp_q.delete();
        pre_q.delete();
        model_cnt  = 0;
        model_ovf  = 0;
        model_idle = 1;
        collecting = 0;
        prev_acc   = 0;
        prev_stall = 0;
    endtask

    task automatic model_start();
        logic [32:0] e;
        exp_q.push_back({1'b0, BSYM});
        collecting = 1;
        model_idle = 0;
        while (pre_q.size() > 0 && collecting) begin
            e = pre_q.pop_front();
            exp_q.push_back({1'b1, e[31:0]});
            if (e[32]) begin
                exp_q.push_back({1'b0, ESYM});
                collecting = 0;
            end
        end
        pre_q.delete();
    endtask

    task automatic ingest(input logic last, input logic [31:0] d);
        if (collecting) begin
            exp_q.push_back({1'b1, d});
            if (last) begin
                exp_q.push_back({1'b0, ESYM});
                collecting = 0;
            end
        end else if (model_idle) begin
            pre_q.push_back({last, d});
        end
    endtask

    // Bus monitor and FIFO occupancy model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            model_reset();
        end else begin
            check("full", 64'(full), 64'(model_cnt == DEPTH));
            check("overflow", 64'(overflow), 64'(model_ovf));
            if (prev_acc) begin
                check("gap_wen", 64'(bus.wen), 64'(0));
                check("gap_addr", 64'(bus.addr), 64'(prev_addr));
                check("gap_data", 64'(bus.data), 64'(prev_data));
            end
            if (prev_stall) begin
                check("stall_wen", 64'(bus.wen), 64'(1));
                check("stall_addr", 64'(bus.addr), 64'(prev_addr));
                check("stall_data", 64'(bus.data), 64'(prev_data));
            end
            if (bus.wen && !bus.stall) begin
                n_writes++;
                acc_cyc.push_back(cyc);
                check("write_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("addr", 64'(bus.addr), 64'(PORT));
                    check("data", 64'(bus.data), 64'(e[31:0]));
                    if (e[32]) begin
                        model_cnt--;
                        n_word_writes++;
                    end
                end
            end
            if (start && model_idle) model_start();
            if (push) begin
                if (model_cnt < DEPTH) begin
                    model_cnt++;
                    ingest(push_last, push_data);
                end else begin
                    model_ovf = 1;
                end
            end
            prev_acc   = bus.wen && !bus.stall;
            prev_stall = bus.wen && bus.stall;
            prev_addr  = bus.addr;
            prev_data  = bus.data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        push      = 1'b0;
        push_data = '0;
        push_last = 1'b0;
        bus.stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_writes      = 0;
        n_word_writes = 0;
        acc_cyc.delete();
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        push      = 1'b1;
        push_data = d;
        push_last = last;
        tick();
        push      = 1'b0;
        push_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int seen);
        seen = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                seen = cyc;
                break;
            end
            tick();
        end
        check("done_reached", 64'(done), 64'(1));
    endtask

    task automatic wait_word(input logic [31:0] d);
        for (int i = 0; i < 40; i++) begin
            if (bus.wen && bus.data == d) break;
            tick();
        end
        check("word_presented", 64'(bus.data), 64'(d));
    endtask

    initial begin
        automatic int done_at;
        automatic logic [31:0] basic[6] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
        automatic logic [29:0] h_addr;
        automatic logic [31:0] h_data;

        // Reset values
        do_reset();
        check("rst_addr", 64'(bus.addr), 64'(0));
        check("rst_data", 64'(bus.data), 64'(0));
        check("rst_wen", 64'(bus.wen), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_full", 64'(full), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));

        // Basic report, with a second start while busy
        for (int i = 0; i < 6; i++) push_word(basic[i], i == 5);
        pulse_start();
        check("start_latency_wen", 64'(bus.wen), 64'(1));
        check("begin_data", 64'(bus.data), 64'(BSYM));
        check("begin_busy", 64'(busy), 64'(1));
        tick();
        tick();
        pulse_start();
        wait_done(100, done_at);
        check("basic_writes", 64'(n_writes), 64'(8));
        check("basic_drained", 64'(exp_q.size()), 64'(0));
        for (int i = 1; i < acc_cyc.size(); i++)
            check("spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(2));
        check("done_latency", 64'(done_at - acc_cyc[acc_cyc.size()-1]), 64'(2));
        check("done_busy", 64'(busy), 64'(0));
        // Start in DONE is ignored
        pulse_start();
        repeat (4) tick();
        check("done_start_wen", 64'(bus.wen), 64'(0));
        check("done_stays", 64'(done), 64'(1));
        check("done_start_writes", 64'(n_writes), 64'(8));

        // Stall held for 5 cycles on a data word
        do_reset();
        push_word(32'd1, 1'b1);
        pulse_start();
        wait_word(32'd1);
        h_addr = bus.addr;
        h_data = bus.data;
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold_wen", 64'(bus.wen), 64'(1));
            check("stall_hold_addr", 64'(bus.addr), 64'(h_addr));
            check("stall_hold_data", 64'(bus.data), 64'(h_data));
        end
        bus.stall = 1'b0;
        wait_done(100, done_at);
        check("stall_word_writes", 64'(n_word_writes), 64'(1));
        check("stall_writes", 64'(n_writes), 64'(3));
        check("stall_drained", 64'(exp_q.size()), 64'(0));

        // Late data: WAIT with wen low until the word arrives
        do_reset();
        pulse_start();
        repeat (10) tick();
        check("wait_wen", 64'(bus.wen), 64'(0));
        check("wait_busy", 64'(busy), 64'(1));
        check("wait_done_low", 64'(done), 64'(0));
        push_word(32'hA5, 1'b1);
        wait_done(100, done_at);
        check("late_writes", 64'(n_writes), 64'(3));
        check("late_drained", 64'(exp_q.size()), 64'(0));

        // Nine pushes into an 8-deep FIFO
        do_reset();
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i), i == 7);
        check("full_after_8", 64'(full), 64'(1));
        check("no_ovf_after_8", 64'(overflow), 64'(0));
        push_word(32'h999, 1'b0);
        check("ovf_after_9", 64'(overflow), 64'(1));
        pulse_start();
        wait_done(200, done_at);
        check("ovf_word_writes", 64'(n_word_writes), 64'(8));
        check("ovf_drained", 64'(exp_q.size()), 64'(0));
        check("ovf_sticky", 64'(overflow), 64'(1));

        // Push and pop in the same cycle while full
        do_reset();
        for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i), i == 7);
        pulse_start();
        wait_word(32'h200);
        check("pp_full_before", 64'(full), 64'(1));
        push_word(32'h3AA, 1'b0);
        check("pp_no_ovf", 64'(overflow), 64'(0));
        check("pp_full_after", 64'(full), 64'(1));
        wait_done(200, done_at);
        check("pp_word_writes", 64'(n_word_writes), 64'(8));
        check("pp_drained", 64'(exp_q.size()), 64'(0));

        // Reset asserted mid-report while a word is presented
        do_reset();
        push_word(32'h11, 1'b0);
        push_word(32'h22, 1'b0);
        push_word(32'h33, 1'b1);
        pulse_start();
        wait_word(32'h11);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wen", 64'(bus.wen), 64'(0));
        check("mid_rst_addr", 64'(bus.addr), 64'(0));
        check("mid_rst_data", 64'(bus.data), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_full", 64'(full), 64'(0));
        check("mid_rst_ovf", 64'(overflow), 64'(0));
        tick();
        rst = 1'b0;
        n_writes = 0;
        push_word(32'h44, 1'b1);
        pulse_start();
        check("fresh_begin_wen", 64'(bus.wen), 64'(1));
        check("fresh_begin_data", 64'(bus.data), 64'(BSYM));
        wait_done(100, done_at);
        check("fresh_writes", 64'(n_writes), 64'(3));
        check("fresh_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
